// File: rtl/pattern_game_pkg.sv
// Shared definitions for the pattern (memory) game core: phase encoding,
// FSM state type and a constant-evaluable ceil(log2) helper.
package pattern_game_pkg;

  localparam logic [2:0] PH_IDLE     = 3'd0;
  localparam logic [2:0] PH_FILL     = 3'd1;
  localparam logic [2:0] PH_SHOW_ON  = 3'd2;
  localparam logic [2:0] PH_SHOW_OFF = 3'd3;
  localparam logic [2:0] PH_INPUT    = 3'd4;
  localparam logic [2:0] PH_PASS     = 3'd5;
  localparam logic [2:0] PH_FAIL     = 3'd6;
  localparam logic [2:0] PH_DONE     = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE     = PH_IDLE,
    ST_FILL     = PH_FILL,
    ST_SHOW_ON  = PH_SHOW_ON,
    ST_SHOW_OFF = PH_SHOW_OFF,
    ST_INPUT    = PH_INPUT,
    ST_PASS     = PH_PASS,
    ST_FAIL     = PH_FAIL,
    ST_DONE     = PH_DONE
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pattern_game_btn_edge.sv
// Button press-edge detector with one-hot check and symbol decode.
module btn_edge #(
  parameter int NUM_BTNS = 5,
  parameter int SYM_W    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btn_i,
  output logic                press_o,
  output logic                onehot_o,
  output logic [SYM_W-1:0]    sym_o
);

  logic [NUM_BTNS-1:0] btn_q;
  logic                found;

  // Remember last cycle's levels so only an all-released to pressed transition counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_q <= '0;
    else        btn_q <= btn_i;
  end

  assign press_o = (btn_q == '0) && (btn_i != '0);

  // One-hot test and index of the lowest set button
  always_comb begin
    onehot_o = (btn_i != '0) && ((btn_i & (btn_i - NUM_BTNS'(1))) == '0);
    sym_o    = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_BTNS; i++) begin
      if (btn_i[i] && !found) begin
        sym_o = SYM_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pattern_game_core.sv
// Pattern game core: fills a random pattern, shows a growing prefix of it,
// checks player presses, and tracks score / high score.
module pattern_game_core
  import pattern_game_pkg::*;
#(
  parameter int NUM_BTNS      = 5,
  parameter int MAX_LEN       = 50,
  parameter int START_LEN     = 1,
  parameter int ON_TICKS      = 2,
  parameter int OFF_TICKS     = 1,
  parameter int TIMEOUT_TICKS = 6,
  parameter int PAUSE_TICKS   = 2,
  localparam int unsigned SYM_W = clog2(NUM_BTNS),
  localparam int unsigned LEN_W = clog2(MAX_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                start,
  input  logic [SYM_W-1:0]    rand_sym,
  input  logic [NUM_BTNS-1:0] btn,
  output logic [2:0]          phase,
  output logic                show_valid,
  output logic [SYM_W-1:0]    show_sym,
  output logic                echo_valid,
  output logic [SYM_W-1:0]    echo_sym,
  output logic [LEN_W-1:0]    score,
  output logic [LEN_W-1:0]    high_score,
  output logic                game_over,
  output logic                win,
  output logic                new_high
);

  localparam int unsigned ADDR_W = clog2(MAX_LEN);
  localparam int unsigned TMR_W  = 16;
  localparam logic [TMR_W-1:0] ON_T    = TMR_W'(ON_TICKS);
  localparam logic [TMR_W-1:0] OFF_T   = TMR_W'(OFF_TICKS);
  localparam logic [TMR_W-1:0] TOUT_T  = TMR_W'(TIMEOUT_TICKS);
  localparam logic [TMR_W-1:0] PAUSE_T = TMR_W'(PAUSE_TICKS);

  state_e            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [LEN_W-1:0]  len_q;
  logic [TMR_W-1:0]  tmr_q;
  logic              show_valid_q, echo_valid_q, game_over_q, win_q, new_high_q;
  logic [SYM_W-1:0]  show_sym_q, echo_sym_q;
  logic [LEN_W-1:0]  score_q, high_q;
  logic [SYM_W-1:0]  mem_q [MAX_LEN];

  logic              press, onehot;
  logic [SYM_W-1:0]  press_sym;

  logic [SYM_W-1:0]  fill_sym, cur_sym, nxt_sym;
  logic [ADDR_W-1:0] idx_inc;
  logic              last_idx, correct, tmr_last, go_fail;
  logic [TMR_W-1:0]  tmr_dec;
  logic [LEN_W-1:0]  fail_score;

  btn_edge #(
    .NUM_BTNS(NUM_BTNS),
    .SYM_W   (SYM_W)
  ) u_btn_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn),
    .press_o (press),
    .onehot_o(onehot),
    .sym_o   (press_sym)
  );

  // Derived values shared by the FSM transitions
  always_comb begin
    // rand_sym < 2*NUM_BTNS, so one conditional subtract is a full modulo;
    // for power-of-two NUM_BTNS the truncated constant is 0 and this is a pass-through
    fill_sym   = (rand_sym >= SYM_W'(NUM_BTNS)) ? rand_sym - SYM_W'(NUM_BTNS) : rand_sym;
    cur_sym    = mem_q[idx_q];
    idx_inc    = (idx_q == ADDR_W'(MAX_LEN - 1)) ? '0 : idx_q + ADDR_W'(1);
    nxt_sym    = mem_q[idx_inc];
    last_idx   = (LEN_W'(idx_q) == len_q - LEN_W'(1));
    correct    = press && onehot && (press_sym == cur_sym);
    tmr_last   = tick && (tmr_q <= TMR_W'(1));
    tmr_dec    = (tmr_q != '0) ? tmr_q - TMR_W'(1) : '0;
    go_fail    = press ? !correct : tmr_last;
    fail_score = (len_q > LEN_W'(START_LEN)) ? len_q - LEN_W'(START_LEN) : '0;
  end

  // Pattern storage; contents are rewritten every game so no reset is needed
  always_ff @(posedge clk) begin
    if (state_q == ST_FILL) mem_q[idx_q] <= fill_sym;
  end

  // Game FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      len_q        <= LEN_W'(START_LEN);
      tmr_q        <= '0;
      show_valid_q <= 1'b0;
      show_sym_q   <= '0;
      echo_valid_q <= 1'b0;
      echo_sym_q   <= '0;
      score_q      <= '0;
      high_q       <= '0;
      game_over_q  <= 1'b0;
      win_q        <= 1'b0;
      new_high_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q      <= ST_FILL;
            idx_q        <= '0;
            len_q        <= LEN_W'(START_LEN);
            tmr_q        <= '0;
            score_q      <= '0;
            game_over_q  <= 1'b0;
            win_q        <= 1'b0;
            new_high_q   <= 1'b0;
            echo_valid_q <= 1'b0;
            echo_sym_q   <= '0;
          end
        end
        ST_FILL: begin
          if (idx_q == ADDR_W'(MAX_LEN - 1)) begin
            state_q      <= ST_SHOW_ON;
            idx_q        <= '0;
            tmr_q        <= ON_T;
            show_valid_q <= 1'b1;
            show_sym_q   <= mem_q[0];
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
        ST_SHOW_ON: begin
          if (tmr_last) begin
            state_q      <= ST_SHOW_OFF;
            tmr_q        <= OFF_T;
            show_valid_q <= 1'b0;
            show_sym_q   <= '0;
          end else if (tick) begin
            tmr_q <= tmr_dec;
          end
        end
        ST_SHOW_OFF: begin
          if (tmr_last) begin
            if (!last_idx) begin
              state_q      <= ST_SHOW_ON;
              idx_q        <= idx_inc;
              tmr_q        <= ON_T;
              show_valid_q <= 1'b1;
              show_sym_q   <= nxt_sym;
            end else begin
              state_q <= ST_INPUT;
              idx_q   <= '0;
              tmr_q   <= TOUT_T;
            end
          end else if (tick) begin
            tmr_q <= tmr_dec;
          end
        end
        ST_INPUT: begin
          // A press edge is resolved before the timer, so it wins over a same-cycle timeout
          if (correct) begin
            echo_valid_q <= 1'b1;
            echo_sym_q   <= press_sym;
            tmr_q        <= TOUT_T;
            if (last_idx) begin
              state_q <= ST_PASS;
              tmr_q   <= PAUSE_T;
              score_q <= len_q;
            end else begin
              idx_q <= idx_inc;
            end
          end else if (go_fail) begin
            state_q <= ST_FAIL;
            tmr_q   <= PAUSE_T;
            score_q <= fail_score;
            if (press) begin
              echo_valid_q <= 1'b0;
              echo_sym_q   <= '0;
            end
          end else if (tick) begin
            tmr_q <= tmr_dec;
          end
        end
        ST_PASS: begin
          if (tmr_last) begin
            if (len_q == LEN_W'(MAX_LEN)) begin
              state_q     <= ST_DONE;
              win_q       <= 1'b1;
              game_over_q <= 1'b1;
              if (score_q > high_q) begin
                high_q     <= score_q;
                new_high_q <= 1'b1;
              end
            end else begin
              state_q      <= ST_SHOW_ON;
              len_q        <= len_q + LEN_W'(1);
              idx_q        <= '0;
              tmr_q        <= ON_T;
              show_valid_q <= 1'b1;
              show_sym_q   <= mem_q[0];
              echo_valid_q <= 1'b0;
              echo_sym_q   <= '0;
            end
          end else if (tick) begin
            tmr_q <= tmr_dec;
          end
        end
        ST_FAIL: begin
          if (tmr_last) begin
            state_q     <= ST_DONE;
            game_over_q <= 1'b1;
            if (score_q > high_q) begin
              high_q     <= score_q;
              new_high_q <= 1'b1;
            end
          end else if (tick) begin
            tmr_q <= tmr_dec;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign phase      = state_q;
  assign show_valid = show_valid_q;
  assign show_sym   = show_sym_q;
  assign echo_valid = echo_valid_q;
  assign echo_sym   = echo_sym_q;
  assign score      = score_q;
  assign high_score = high_q;
  assign game_over  = game_over_q;
  assign win        = win_q;
  assign new_high   = new_high_q;

endmodule

// File: tb/tb_pattern_game_core.sv
// Directed bench for pattern_game_core with a queue of expected shown symbols.
module tb_pattern_game_core;
  import pattern_game_pkg::*;

  localparam int NB = 5;
  localparam int ML = 50;

  logic       clk = 1'b0;
  logic       rst_n, tick, start;
  logic [2:0] rand_sym;
  logic [4:0] btn;
  logic [2:0] phase;
  logic       show_valid, echo_valid, game_over, win, new_high;
  logic [2:0] show_sym, echo_sym;
  logic [5:0] score, high_score;

  int unsigned n_pass = 0, n_fail = 0, n_total = 0;
  int unsigned tick_mode = 0;
  bit          tick_ph = 1'b0;
  logic        sv_prev = 1'b0;
  logic [2:0]  exp_mem [ML];
  logic [2:0]  sq [$];

  pattern_game_core #(
    .NUM_BTNS(5), .MAX_LEN(50), .START_LEN(1), .ON_TICKS(2),
    .OFF_TICKS(1), .TIMEOUT_TICKS(6), .PAUSE_TICKS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .rand_sym(rand_sym),
    .btn(btn), .phase(phase), .show_valid(show_valid), .show_sym(show_sym),
    .echo_valid(echo_valid), .echo_sym(echo_sym), .score(score),
    .high_score(high_score), .game_over(game_over), .win(win), .new_high(new_high)
  );

  always #5 clk = ~clk;

  // tick_mode: 0 never, 1 every cycle, 2 every other cycle
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_ph = ~tick_ph;
      tick = (tick_mode == 1) || (tick_mode == 2 && tick_ph);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    sv_prev = show_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input logic [2:0] target, input int budget, input string tag);
    for (int n = 0; n < budget && phase !== target; n++) cyc();
    chk(tag, phase, target);
  endtask

  task automatic next_show(input bit allow_now, output bit ok);
    ok = allow_now && show_valid && !sv_prev;
    for (int n = 0; n < 200 && !ok; n++) begin
      cyc();
      ok = show_valid && !sv_prev;
    end
  endtask

  task automatic start_game(input int pat);
    logic [2:0] v;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("fill_enter", phase, ST_FILL);
    chk("score_clr", score, 0);
    chk("gover_clr", game_over, 0);
    chk("win_clr", win, 0);
    chk("newhigh_clr", new_high, 0);
    for (int a = 0; a < ML; a++) begin
      v = (pat == 0) ? 3'(a % 5) : 3'((a * 3 + 1) % 8);
      rand_sym = v;
      exp_mem[a] = 3'(int'(v) % NB);
      cyc();
      if (a == ML - 2) chk("fill_len", phase, ST_FILL);
    end
    chk("fill_done", phase, ST_SHOW_ON);
  endtask

  task automatic show_round(input int len);
    bit ok;
    logic [2:0] e;
    for (int i = 0; i < len; i++) sq.push_back(exp_mem[i]);
    for (int i = 0; i < len; i++) begin
      next_show(i == 0, ok);
      chk("show_seen", 32'(ok), 1);
      e = sq.pop_front();
      chk("show_sym", show_sym, e);
      if (i == 0) chk("echo_clr", echo_valid, 0);
    end
    wait_phase(ST_INPUT, 100, "enter_input");
  endtask

  task automatic play_round(input int len, input int wrong_at);
    logic [2:0] tgt;
    show_round(len);
    for (int i = 0; i < len; i++) begin
      if (i == wrong_at) begin
        btn = 5'b00001 << ((int'(exp_mem[i]) + 1) % NB);
        cyc();
        chk("wrong_fail", phase, ST_FAIL);
        chk("fail_score", score, len - 1);
        btn = '0;
        cyc();
        return;
      end
      btn = 5'b00001 << exp_mem[i];
      cyc();
      chk("echo_valid", echo_valid, 1);
      chk("echo_sym", echo_sym, exp_mem[i]);
      tgt = (i == len - 1) ? ST_PASS : ST_INPUT;
      chk("after_press", phase, tgt);
      if (i == len - 1) chk("pass_score", score, len);
      btn = '0;
      cyc();
    end
  endtask

  task automatic finish_game(input int s, input int w, input int nh, input int hs);
    wait_phase(ST_DONE, 50, "reach_done");
    chk("game_over", game_over, 1);
    chk("final_score", score, s);
    chk("win", win, w);
    chk("new_high", new_high, nh);
    chk("high_score", high_score, hs);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; rand_sym = '0; btn = '0;
    #3;
    chk("rst_phase", phase, ST_IDLE);
    chk("rst_show", {show_valid, show_sym}, 0);
    chk("rst_echo", {echo_valid, echo_sym}, 0);
    chk("rst_scores", {score, high_score}, 0);
    chk("rst_flags", {game_over, win, new_high}, 0);
    #9 rst_n = 1'b1;
    cyc();
    chk("idle_hold", phase, ST_IDLE);

    // Game A: full win to length 50
    tick_mode = 2;
    start_game(0);
    for (int r = 1; r <= ML; r++) play_round(r, -1);
    finish_game(50, 1, 1, 50);

    // Game B: wrong single button in round 3
    start_game(0);
    play_round(1, -1);
    play_round(2, -1);
    play_round(3, 2);
    finish_game(2, 0, 0, 50);

    // Game C: timeout on the 6th tick
    tick_mode = 1;
    start_game(0);
    show_round(1);
    repeat (5) cyc();
    chk("to_wait", phase, ST_INPUT);
    cyc();
    chk("to_fail", phase, ST_FAIL);
    finish_game(0, 0, 0, 50);

    // Game D: press on the timeout tick, ignored start, held button, multi-bit press
    start_game(0);
    show_round(1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    chk("start_ignored", phase, ST_INPUT);
    btn = 5'b00001 << exp_mem[0];
    cyc();
    chk("press_beats_to", phase, ST_PASS);
    chk("press_score", score, 1);
    btn = '0;
    cyc();
    show_round(2);
    btn = 5'b00001 << exp_mem[0];
    cyc();
    chk("hold_echo", echo_sym, exp_mem[0]);
    repeat (2) cyc();
    chk("hold_once", phase, ST_INPUT);
    btn = '0;
    cyc();
    btn = 5'b00001 << exp_mem[1];
    cyc();
    chk("hold_pass", phase, ST_PASS);
    btn = '0;
    cyc();
    show_round(3);
    btn = 5'b00110;
    cyc();
    chk("multi_fail", phase, ST_FAIL);
    chk("multi_score", score, 2);
    btn = '0;
    finish_game(2, 0, 0, 50);

    // Game E: asynchronous reset during SHOW_ON of round 4
    tick_mode = 2;
    start_game(1);
    for (int r = 1; r <= 3; r++) play_round(r, -1);
    begin
      bit ok;
      sq.push_back(exp_mem[0]);
      next_show(1'b0, ok);
      chk("r4_show_seen", 32'(ok), 1);
      chk("r4_show_sym", show_sym, sq.pop_front());
      sq.delete();
    end
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_phase", phase, ST_IDLE);
    chk("mid_rst_show", {show_valid, show_sym}, 0);
    chk("mid_rst_echo", {echo_valid, echo_sym}, 0);
    chk("mid_rst_scores", {score, high_score}, 0);
    chk("mid_rst_flags", {game_over, win, new_high}, 0);
    #2 rst_n = 1'b1;
    cyc();

    // Games F/G/H: equal score does not set new_high, a higher one does
    start_game(1);
    for (int r = 1; r <= 3; r++) play_round(r, -1);
    play_round(4, 0);
    finish_game(3, 0, 1, 3);
    start_game(1);
    for (int r = 1; r <= 3; r++) play_round(r, -1);
    play_round(4, 2);
    finish_game(3, 0, 0, 3);
    start_game(1);
    for (int r = 1; r <= 4; r++) play_round(r, -1);
    play_round(5, 1);
    finish_game(4, 0, 1, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
